// File: rtl/serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_alu_ctrl
// Purpose  : Bit-serial ALU sequencer. It runs a 1-bit slice LSB first over
//            WIDTH cycles and then registers the result and the flags.
// Revision : 1.0 - initial release
// ============================================================================
module serial_alu_ctrl #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);
    localparam logic [2:0]       c_op_sub   = 3'b011;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [2:0]       r_op;
    logic             r_carry;
    logic             r_cin_msb;
    logic [CNT_W-1:0] r_cnt;

    logic w_accept;
    logic w_last;
    logic w_is_arith;
    logic w_bx;
    logic w_sum;
    logic w_cout;

    // The DONE cycle is already IDLE, so a held start is accepted right after done.
    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_last     = (r_cnt == c_last_bit);
    assign w_is_arith = (r_op[2:1] == 2'b01);

    // One-bit ALU slice
    always_comb begin
        w_bx   = r_b_sh[0] ^ r_op[0];
        w_sum  = 1'b0;
        w_cout = 1'b0;
        case (r_op)
            3'b000: w_sum = r_b_sh[0];
            3'b010,
            3'b011: begin
                w_sum  = r_a_sh[0] ^ w_bx ^ r_carry;
                w_cout = (r_a_sh[0] & w_bx) | (r_a_sh[0] & r_carry) | (w_bx & r_carry);
            end
            3'b100: w_sum = r_a_sh[0] & r_b_sh[0];
            3'b101: w_sum = r_a_sh[0] | r_b_sh[0];
            3'b110: w_sum = r_a_sh[0] ^ r_b_sh[0];
            default: w_sum = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_res_sh  <= '0;
            r_op      <= 3'b000;
            r_carry   <= 1'b0;
            r_cin_msb <= 1'b0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh  <= A;
                        r_b_sh  <= B;
                        r_op    <= cntrl;
                        r_carry <= (cntrl == c_op_sub);
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_res_sh <= {w_sum, r_res_sh[WIDTH-1:1]};
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry  <= w_cout;
                    if (w_last) begin
                        r_cin_msb <= r_carry;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    result    <= r_res_sh;
                    negative  <= r_res_sh[WIDTH-1];
                    zero      <= ~|r_res_sh;
                    carry_out <= w_is_arith & r_carry;
                    overflow  <= w_is_arith & (r_cin_msb ^ r_carry);
                    done      <= 1'b1;
                    r_cnt     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_alu_ctrl
// Purpose  : Self-checking bench for serial_alu_ctrl (WIDTH=8 and WIDTH=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_alu_ctrl;

    localparam int W8 = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start8;
    logic [7:0]  a8, b8;
    logic [2:0]  op8;
    logic        busy8, done8, n8, z8, v8, c8;
    logic [7:0]  res8;
    logic        start64;
    logic [63:0] a64, b64;
    logic [2:0]  op64;
    logic        busy64, done64, n64, z64, v64, c64;
    logic [63:0] res64;

    always #5 clk = ~clk;

    serial_alu_ctrl #(.WIDTH(W8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .A(a8), .B(b8), .cntrl(op8),
        .busy(busy8), .done(done8), .result(res8), .negative(n8), .zero(z8),
        .overflow(v8), .carry_out(c8)
    );

    serial_alu_ctrl #(.WIDTH(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .start(start64), .A(a64), .B(b64), .cntrl(op64),
        .busy(busy64), .done(done64), .result(res64), .negative(n64), .zero(z64),
        .overflow(v64), .carry_out(c64)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] res;
        logic       n, z, v, c;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       n, z, v, c;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   stray = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        exp_t       e;
        logic [8:0] s;
        logic [7:0] bb;
        e.v = 1'b0;
        e.c = 1'b0;
        e.acc = 0;
        bb = (op == 3'b011) ? ~b : b;
        case (op)
            3'b000: e.res = b;
            3'b010, 3'b011: begin
                s = {1'b0, a} + {1'b0, bb} + ((op == 3'b011) ? 9'd1 : 9'd0);
                e.res = s[7:0];
                e.c = s[8];
                e.v = (a[7] == bb[7]) && (e.res[7] != a[7]);
            end
            3'b100: e.res = a & b;
            3'b101: e.res = a | b;
            3'b110: e.res = a ^ b;
            default: e.res = 8'h00;
        endcase
        e.n = e.res[7];
        e.z = (e.res == 8'h00);
        return e;
    endfunction

    // Scoreboard: every done pops the oldest accepted operation
    always @(negedge clk) begin
        if (reset_n && done8 === 1'b1) begin
            if (q.size() == 0) begin
                stray++;
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", 64'(res8), 64'(e.res));
                chk("negative", 64'(n8), 64'(e.n));
                chk("zero", 64'(z8), 64'(e.z));
                chk("overflow", 64'(v8), 64'(e.v));
                chk("carry_out", 64'(c8), 64'(e.c));
                chk("latency", 64'(cyc - e.acc), 64'(W8 + 1));
                chk("busy_with_done", 64'(busy8), 64'd1);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!(busy8 === 1'b0 || done8 === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: busy %0b", busy8);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done8 !== 1'b1 && n < 100);
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: done %0b", done8);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input exp_t e, input bit push);
        exp_t t;
        wait_ready();
        a8 = a;
        b8 = b;
        op8 = op;
        start8 = 1'b1;
        if (push) begin
            t = e;
            t.acc = cyc + 1;
            q.push_back(t);
        end
        @(negedge clk);
        start8 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        exp_t e;
        int   n;
        int   acc64;

        tbl[0]  = '{8'h7F, 8'h01, 3'b010, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{8'h35, 8'h35, 3'b011, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{8'h00, 8'h01, 3'b011, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{8'hCA, 8'h5C, 3'b100, 8'h48, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{8'hCA, 8'h5C, 3'b101, 8'hDE, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{8'hCA, 8'h5C, 3'b110, 8'h96, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{8'hCA, 8'h5C, 3'b000, 8'h5C, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{8'hCA, 8'h5C, 3'b111, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{8'hFF, 8'hFF, 3'b001, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{8'hFF, 8'h01, 3'b010, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{8'h80, 8'h01, 3'b011, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{8'h7F, 8'hFF, 3'b011, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{8'hFF, 8'hFF, 3'b010, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1};

        reset_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
        start64 = 1'b0; a64 = '0; b64 = '0; op64 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);
        chk("rst_result", 64'(res8), 64'd0);
        chk("rst_flags", 64'({n8, z8, v8, c8}), 64'd0);
        chk("rst_busy64", 64'(busy64), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            e.res = tbl[i].res; e.n = tbl[i].n; e.z = tbl[i].z;
            e.v = tbl[i].v; e.c = tbl[i].c; e.acc = 0;
            issue(tbl[i].a, tbl[i].b, tbl[i].op, e, 1'b1);
        end

        for (int i = 0; i < 16; i++) begin
            logic [7:0] ra, rb;
            logic [2:0] rop;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rop = 3'($urandom_range(0, 7));
            issue(ra, rb, rop, model(ra, rb, rop), 1'b1);
        end

        // start held high: one accept right after each done
        wait_ready();
        a8 = 8'h10; b8 = 8'h20; op8 = 3'b010; start8 = 1'b1;
        e = model(8'h10, 8'h20, 3'b010); e.acc = cyc + 1; q.push_back(e);
        wait_done();
        a8 = 8'h05; b8 = 8'h03; op8 = 3'b011;
        e = model(8'h05, 8'h03, 3'b011); e.acc = cyc + 1; q.push_back(e);
        wait_done();
        a8 = 8'hF0; b8 = 8'h0F; op8 = 3'b110;
        e = model(8'hF0, 8'h0F, 3'b110); e.acc = cyc + 1; q.push_back(e);
        @(negedge clk);
        start8 = 1'b0;

        // operand changes and a second start while busy must not disturb the op
        issue(8'h12, 8'h34, 3'b010, model(8'h12, 8'h34, 3'b010), 1'b1);
        repeat (3) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; op8 = 3'b111; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;

        n = 0;
        while ((q.size() != 0 || busy8) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
        chk("idle_after_done", 64'(busy8), 64'd0);

        // abort mid-run: outputs clear at once and no done follows
        issue(8'h0F, 8'h01, 3'b010, e, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy8), 64'd0);
        chk("abort_done", 64'(done8), 64'd0);
        chk("abort_result", 64'(res8), 64'd0);
        chk("abort_flags", 64'({n8, z8, v8, c8}), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("stray_done", 64'(stray), 64'd0);

        // WIDTH=64 carry propagates across every bit
        a64 = '1; b64 = 64'd1; op64 = 3'b010; start64 = 1'b1;
        acc64 = cyc + 1;
        @(negedge clk);
        start64 = 1'b0;
        n = 0;
        while (done64 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("w64_latency", 64'(cyc - acc64), 64'd65);
        chk("w64_result", res64, 64'd0);
        chk("w64_zero", 64'(z64), 64'd1);
        chk("w64_carry", 64'(c64), 64'd1);
        chk("w64_ovf_neg", 64'({v64, n64}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
